iob_eth_mii_tx: RTL and testbench



---
 rtl/iob_eth_pkg.sv | 27 ++
 rtl/iob_eth_crc32_nibble.sv | 26 ++
 rtl/iob_eth_mii_tx.sv | 159 +++++++++++++++
 tb/tb_iob_eth_mii_tx.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/iob_eth_pkg.sv
// Shared Ethernet definitions: framer state encoding, MII framing constants
// and CRC-32 parameters used by both transmit and receive paths.
package iob_eth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_SFD      = 3'd2,
    ST_DATA     = 3'd3,
    ST_FCS      = 3'd4,
    ST_IFG      = 3'd5
  } tx_state_t;

  localparam logic [3:0]  PREAMBLE_NIBBLE = 4'h5;
  localparam logic [3:0]  SFD_NIBBLE      = 4'hD;
  localparam logic [31:0] CRC_POLY        = 32'h04C11DB7;
  localparam logic [31:0] CRC_POLY_REFL   = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT        = 32'hFFFFFFFF;
  localparam int          PREAMBLE_LEN    = 14;
  localparam int          FCS_NIBBLES     = 8;

  // The FCS goes out complemented, least significant nibble first.
  function automatic logic [3:0] fcs_nibble(input logic [31:0] crc);
    return ~crc[3:0];
  endfunction

endpackage

// File: rtl/iob_eth_crc32_nibble.sv
// Reflected CRC-32 (IEEE 802.3) advanced by one nibble, bit 0 first.
// Purely combinational; shared by the transmit framer and the receive FCS checker.
module iob_eth_crc32_nibble
  import iob_eth_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [3:0]  nibble_i,
  output logic [31:0] crc_o
);

  logic [31:0] crc_v;

  // Four serial LFSR steps unrolled.
  always_comb begin
    crc_v = crc_i;
    for (int i = 0; i < 4; i++) begin
      if (crc_v[0] ^ nibble_i[i]) begin
        crc_v = {1'b0, crc_v[31:1]} ^ CRC_POLY_REFL;
      end else begin
        crc_v = {1'b0, crc_v[31:1]};
      end
    end
    crc_o = crc_v;
  end

endmodule

// File: rtl/iob_eth_mii_tx.sv
// MII transmit framer: preamble/SFD, nibble-serialised payload, CRC-32 FCS
// and inter-frame gap, fed by a valid/ready byte stream.
module iob_eth_mii_tx
  import iob_eth_pkg::*;
#(
  parameter int IFG_NIBBLES = 24
) (
  input  logic       clk_i,
  input  logic       cke_i,
  input  logic       arst_i,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  input  logic       last_i,
  output logic       ready_o,
  output logic [3:0] mii_txd_o,
  output logic       mii_tx_en_o,
  output logic       busy_o,
  output logic       underrun_o
);

  localparam int CNT_MAX = (IFG_NIBBLES > PREAMBLE_LEN) ? IFG_NIBBLES : PREAMBLE_LEN;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  tx_state_t        state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [31:0]      crc_r;
  logic [31:0]      crc_next_s;
  logic [3:0]       crc_nibble_s;
  logic [3:0]       byte_hi_r;
  logic             last_r;
  logic             phase_r;
  logic [3:0]       txd_r;
  logic             tx_en_r;
  logic             ready_r;
  logic             busy_r;
  logic             underrun_r;

  // A transfer cycle loads the new low nibble straight from data_i; otherwise
  // the stored high nibble is the one being sent next.
  always_comb begin
    if (ready_r) begin
      crc_nibble_s = data_i[3:0];
    end else begin
      crc_nibble_s = byte_hi_r;
    end
  end

  iob_eth_crc32_nibble u_crc (
    .crc_i    (crc_r),
    .nibble_i (crc_nibble_s),
    .crc_o    (crc_next_s)
  );

  // Framer FSM; the CRC advances in the same edge that loads a payload nibble.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      crc_r      <= CRC_INIT;
      byte_hi_r  <= 4'h0;
      last_r     <= 1'b0;
      phase_r    <= 1'b0;
      txd_r      <= 4'h0;
      tx_en_r    <= 1'b0;
      ready_r    <= 1'b0;
      busy_r     <= 1'b0;
      underrun_r <= 1'b0;
    end else if (cke_i) begin
      underrun_r <= 1'b0;
      if (ready_r) begin
        ready_r <= 1'b0;
        if (valid_i) begin
          state_r   <= ST_DATA;
          byte_hi_r <= data_i[7:4];
          last_r    <= last_i;
          phase_r   <= 1'b0;
          txd_r     <= data_i[3:0];
          crc_r     <= crc_next_s;
        end else begin
          state_r    <= ST_IFG;
          cnt_r      <= CNT_W'(IFG_NIBBLES - 1);
          txd_r      <= 4'h0;
          tx_en_r    <= 1'b0;
          underrun_r <= 1'b1;
        end
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (valid_i) begin
              state_r <= ST_PREAMBLE;
              cnt_r   <= CNT_W'(PREAMBLE_LEN - 1);
              crc_r   <= CRC_INIT;
              txd_r   <= PREAMBLE_NIBBLE;
              tx_en_r <= 1'b1;
              busy_r  <= 1'b1;
            end
          end
          ST_PREAMBLE: begin
            if (cnt_r == '0) begin
              state_r <= ST_SFD;
            end else begin
              cnt_r <= cnt_r - CNT_W'(1);
            end
          end
          ST_SFD: begin
            txd_r   <= SFD_NIBBLE;
            ready_r <= 1'b1;
          end
          ST_DATA: begin
            if (!phase_r) begin
              txd_r   <= byte_hi_r;
              crc_r   <= crc_next_s;
              phase_r <= 1'b1;
              ready_r <= ~last_r;
            end else begin
              state_r <= ST_FCS;
              cnt_r   <= CNT_W'(FCS_NIBBLES - 1);
              txd_r   <= fcs_nibble(crc_r);
              crc_r   <= {4'hF, crc_r[31:4]};
            end
          end
          ST_FCS: begin
            if (cnt_r == '0) begin
              state_r <= ST_IFG;
              cnt_r   <= CNT_W'(IFG_NIBBLES - 1);
              txd_r   <= 4'h0;
              tx_en_r <= 1'b0;
            end else begin
              cnt_r <= cnt_r - CNT_W'(1);
              txd_r <= fcs_nibble(crc_r);
              crc_r <= {4'hF, crc_r[31:4]};
            end
          end
          ST_IFG: begin
            if (cnt_r == '0) begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end else begin
              cnt_r <= cnt_r - CNT_W'(1);
            end
          end
          default: begin
            state_r <= ST_IDLE;
            txd_r   <= 4'h0;
            tx_en_r <= 1'b0;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ready_o     = ready_r;
  assign mii_txd_o   = txd_r;
  assign mii_tx_en_o = tx_en_r;
  assign busy_o      = busy_r;
  assign underrun_o  = underrun_r;

endmodule

// File: tb/tb_iob_eth_mii_tx.sv
// Randomised self-checking bench for iob_eth_mii_tx against a cycle-level
// frame model built from the framing rules and a bytewise CRC-32.
module tb_iob_eth_mii_tx;

  localparam int IFG = 24;

  logic       clk = 1'b0;
  logic       cke;
  logic       arst;
  logic [7:0] data;
  logic       valid;
  logic       last;
  logic       ready;
  logic [3:0] txd;
  logic       tx_en;
  logic       busy;
  logic       underrun;

  int checks   = 0;
  int failures = 0;

  logic [7:0] pl_q[$];
  logic [7:0] exp_q[$];

  iob_eth_mii_tx #(.IFG_NIBBLES(IFG)) dut (
    .clk_i       (clk),
    .cke_i       (cke),
    .arst_i      (arst),
    .data_i      (data),
    .valid_i     (valid),
    .last_i      (last),
    .ready_o     (ready),
    .mii_txd_o   (txd),
    .mii_tx_en_o (tx_en),
    .busy_o      (busy),
    .underrun_o  (underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Standard bytewise reflected CRC-32; returns the FCS as sent (byte 0 in [7:0]).
  function automatic logic [31:0] ref_fcs();
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (pl_q[i]) begin
      c = c ^ {24'h0, pl_q[i]};
      for (int b = 0; b < 8; b++) begin
        if (c[0]) c = {1'b0, c[31:1]} ^ 32'hEDB88320;
        else      c = {1'b0, c[31:1]};
      end
    end
    return ~c;
  endfunction

  // Expected {tx_en, txd, busy, ready, underrun} for each enabled cycle from cycle 0.
  task automatic build_exp(input int under_j);
    int n = pl_q.size();
    int e;
    int k;
    int f;
    logic [31:0] fcs = ref_fcs();
    logic [3:0]  nib;
    logic        rdy;
    exp_q.delete();
    exp_q.push_back(8'h00);
    if (under_j < 0)       e = 16 + 2 * n + 8;
    else if (under_j == 0) e = 16;
    else                   e = 18 + 2 * (under_j - 1);
    for (int t = 1; t <= e; t++) begin
      if (t <= 15) begin
        nib = 4'h5; rdy = 1'b0;
      end else if (t == 16) begin
        nib = 4'hD; rdy = 1'b1;
      end else if (t <= 16 + 2 * n) begin
        k = (t - 17) / 2;
        if (((t - 17) % 2) == 0) begin
          nib = pl_q[k][3:0]; rdy = 1'b0;
        end else begin
          nib = pl_q[k][7:4]; rdy = (k < n - 1);
        end
      end else begin
        f = t - 17 - 2 * n;
        nib = fcs[4*f +: 4]; rdy = 1'b0;
      end
      exp_q.push_back({1'b1, nib, 1'b1, rdy, 1'b0});
    end
    for (int t = 1; t <= IFG; t++) begin
      exp_q.push_back({1'b0, 4'h0, 1'b1, 1'b0, (under_j >= 0 && t == 1)});
    end
  endtask

  // Starts and ends at a falling edge; one loop pass per clock, records only enabled cycles.
  task automatic run_frame(input string name, input int under_j, input bit rand_cke,
                           input int stop_at, output int en_cnt, output int ifg_cnt,
                           output logic [31:0] fcs_obs);
    int n = pl_q.size();
    int idx = 0;
    int rec = 0;
    int raw = 0;
    int lim;
    logic [7:0] obs;
    build_exp(under_j);
    lim = exp_q.size();
    if (stop_at > 0 && stop_at < lim) lim = stop_at;
    en_cnt = 0;
    ifg_cnt = 0;
    fcs_obs = 32'h0;
    while (rec < lim && raw < 20 * lim + 100) begin
      cke = rand_cke ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (rec == 0) begin
        valid = 1'b1; data = pl_q[0]; last = (n == 1);
      end else if (ready && idx == under_j) begin
        valid = 1'b0; data = 8'($urandom); last = 1'b0;
      end else if (ready && idx < n) begin
        valid = 1'b1; data = pl_q[idx]; last = (idx == n - 1);
      end else begin
        valid = 1'($urandom_range(0, 1)); data = 8'($urandom); last = 1'($urandom_range(0, 1));
      end
      if (cke) begin
        obs = {tx_en, txd, busy, ready, underrun};
        check($sformatf("%s cyc%0d", name, rec), 32'(obs), 32'(exp_q[rec]));
        if (tx_en) begin
          if (en_cnt >= 16 + 2 * n && en_cnt < 24 + 2 * n)
            fcs_obs[4*(en_cnt-16-2*n) +: 4] = txd;
          en_cnt++;
        end
        if (busy && !tx_en) ifg_cnt++;
        if (ready && valid) idx++;
        rec++;
      end
      raw++;
      @(negedge clk);
    end
    if (rec < lim) check({name, " timeout"}, 32'(rec), 32'(lim));
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      cke = 1'b1; valid = 1'b0; last = 1'b0;
      check("idle", 32'({busy, tx_en, txd, ready, underrun}), 32'h0);
      @(negedge clk);
    end
  endtask

  task automatic load_123456789();
    pl_q.delete();
    for (int i = 0; i < 9; i++) pl_q.push_back(8'h31 + 8'(i));
  endtask

  task automatic load_random(input int n);
    pl_q.delete();
    for (int i = 0; i < n; i++) pl_q.push_back(8'($urandom));
  endtask

  initial begin
    int en_cnt;
    int ifg_cnt;
    logic [31:0] fcs_obs;

    arst = 1'b1; cke = 1'b1; valid = 1'b1; data = 8'h31; last = 1'b0;
    #22;
    check("reset_outputs", 32'({ready, txd, tx_en, busy, underrun}), 32'h0);
    @(negedge clk);
    arst = 1'b0;

    // Known vector right out of reset, valid already high.
    load_123456789();
    run_frame("crc9", -1, 1'b0, 0, en_cnt, ifg_cnt, fcs_obs);
    check("crc9 fcs", fcs_obs, 32'hCBF43926);
    check("crc9 en_len", 32'(en_cnt), 32'd42);
    check("crc9 ifg", 32'(ifg_cnt), 32'(IFG));
    idle(3);

    // Back-to-back single-byte frames; the second starts in the first IDLE cycle.
    load_random(1);
    run_frame("b2b1", -1, 1'b0, 0, en_cnt, ifg_cnt, fcs_obs);
    check("b2b1 ifg", 32'(ifg_cnt), 32'(IFG));
    check("b2b1 fcs", fcs_obs, ref_fcs());
    load_random(1);
    run_frame("b2b2", -1, 1'b0, 0, en_cnt, ifg_cnt, fcs_obs);
    check("b2b2 ifg", 32'(ifg_cnt), 32'(IFG));
    check("b2b2 en_len", 32'(en_cnt), 32'd26);
    idle(2);

    // Underrun at byte 2 of 4, then at the SFD slot with a gated clock.
    load_random(4);
    run_frame("urun", 1, 1'b0, 0, en_cnt, ifg_cnt, fcs_obs);
    check("urun en_len", 32'(en_cnt), 32'd18);
    check("urun ifg", 32'(ifg_cnt), 32'(IFG));
    idle(2);
    load_random(3);
    run_frame("urun0", 0, 1'b1, 0, en_cnt, ifg_cnt, fcs_obs);
    check("urun0 en_len", 32'(en_cnt), 32'd16);
    idle(2);

    // 60-byte frame with and without clock-enable gaps.
    load_random(60);
    run_frame("long", -1, 1'b0, 0, en_cnt, ifg_cnt, fcs_obs);
    check("long en_len", 32'(en_cnt), 32'd144);
    run_frame("long_cke", -1, 1'b1, 0, en_cnt, ifg_cnt, fcs_obs);
    check("long_cke en_len", 32'(en_cnt), 32'd144);
    check("long_cke fcs", fcs_obs, ref_fcs());
    idle(2);

    // Reset in the middle of the payload, then a clean known frame.
    load_random(10);
    run_frame("mid", -1, 1'b0, 25, en_cnt, ifg_cnt, fcs_obs);
    #2 arst = 1'b1;
    #1 check("midrst outputs", 32'({ready, txd, tx_en, busy, underrun}), 32'h0);
    @(negedge clk);
    arst = 1'b0;
    idle(2);
    load_123456789();
    run_frame("post", -1, 1'b0, 0, en_cnt, ifg_cnt, fcs_obs);
    check("post fcs", fcs_obs, 32'hCBF43926);
    check("post en_len", 32'(en_cnt), 32'd42);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
